spi_master_byte: RTL
====================

# spi_master_byte

Byte-oriented SPI controller (mode 0, MSB first) that drives SCLK, MOSI and CS and samples MISO. It is the initiator end of the board's SPI link and talks to our FPGA SPI peripheral. The host logic supplies one byte per handshake and receives the byte shifted in on MISO. An optional hold keeps CS asserted across multi-byte transactions.

## Interface
Parameters:
- CLKDIV, 4: sysclk cycles per SCLK half-period; legal range ≥4, required to absorb the MISO synchronizer.
- CS_GAP, 2: minimum sysclk cycles CS stays high between transactions; must be ≥1.

Ports:
- sysclk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- iStart  in  1  byte request; accepted only when oBusy=0
- iTx  in  8  byte to send; sampled on the accept cycle
- iHold  in  1  sampled on accept; 1 keeps CS low after this byte. In HOLDWAIT, 0 ends the transaction.
- oBusy  out  1  1 while a byte or CS gap is in progress
- oRxReady  out  1  one-cycle pulse; oRx is valid
- oRx  out  8  last received byte; holds until next pulse
- oSPIClk  out  1  SCLK, idle low
- oSPIMOSI  out  1  MOSI
- iSPIMISO  in  1  MISO, asynchronous; passes through a 2-FF synchronizer
- oSPICS  out  1  chip select, active low
- probe  out  16  debug bus (see Configuration)

## Operation
- States: IDLE, SETUP, HIGH, LOW, TAIL, HOLDWAIT, GAP.
- Half-period counter runs 0..CLKDIV-1. Every SETUP/HIGH/LOW/TAIL state lasts exactly CLKDIV cycles. Bit counter is 3 bits.
- IDLE: CS=1, SCLK=0, oBusy=0.
  - iStart → load iTx into shift register, latch iHold, go to SETUP.
- SETUP: CS=0, SCLK=0, MOSI=shift[7] → HIGH.
- HIGH: SCLK=1. On the last cycle, capture the synchronized MISO into rx[0] (rx shifts left) and increment the bit counter.
  - If 8 bits are done → TAIL.
  - Otherwise → LOW.
- LOW: SCLK=0, MOSI=next bit (shift left) → HIGH.
- TAIL: SCLK=0, CS stays low.
  - On the first cycle: oRx←rx and oRxReady=1.
  - At the end: if the latched hold=1 → HOLDWAIT, else → GAP.
- HOLDWAIT: CS=0, SCLK=0, oBusy=0.
  - iStart → load byte, latch iHold, go to LOW with MOSI=new bit7. There is no SETUP phase.
  - Else if iHold=0 → GAP.
  - If iStart=1 and iHold=0 in the same cycle, the start wins.
- GAP: CS=1, oBusy=1 for CS_GAP cycles → IDLE.
- iStart while oBusy=1 is ignored; iTx is not sampled.
- MOSI is 0 in IDLE and GAP. MISO is only sampled in HIGH.
- Reset values: oSPICS=1, oSPIClk=0, oSPIMOSI=0, oBusy=0, oRxReady=0, oRx=0x00, probe=0, state=IDLE.
- Reset mid-byte: outputs return to reset values on the next edge. No oRxReady. No GAP is enforced.

## Timing
- Accept at cycle 0 in IDLE:
  - CS falls at cycle 1.
  - First SCLK rise at cycle 1+CLKDIV.
  - oRxReady at cycle 1+16·CLKDIV.
  - CS rises at 1+17·CLKDIV when not held.
  - oBusy falls at 1+17·CLKDIV+CS_GAP.
- Accept in HOLDWAIT at cycle h: first SCLK rise at h+1+CLKDIV; oRxReady at h+1+16·CLKDIV.
- SCLK duty is exactly 50%. Period is 2·CLKDIV cycles.
- MOSI changes only while SCLK=0, at least CLKDIV cycles before each rising edge.
- MISO sample point is the last sysclk cycle before SCLK falls.

## Configuration
- SPI_MASTER_PROBE_EN defined: probe = {state[2:0], bitcnt[2:0], oSPICS, oSPIClk, shift[7:0]}, registered.
- SPI_MASTER_PROBE_EN undefined: probe is tied to 16'h0000, and no probe registers are built.
- The port list is identical in both builds.

## Test plan
- Reset, CLKDIV=4, CS_GAP=2, iStart with iTx=0xA5, iHold=0; MISO model returns 0x3C → MOSI at rising edges is 1,0,1,0,0,1,0,1; oRxReady at cycle 65 with oRx=0x3C; CS high at cycle 69; oBusy low at cycle 71.
- Held pair: iTx=0x01 with iHold=1, then 0x80 with iHold=0 issued in HOLDWAIT → CS stays low across both bytes; 16 SCLK rises; two oRxReady pulses; single CS rise after the second TAIL.
- HOLDWAIT with iHold dropped and no iStart → GAP next cycle; CS high for 2 cycles; 8 SCLK rises total.
- iStart=1, iTx=0xFF at cycle 10 during a 0xA5 transfer → MOSI pattern unchanged; exactly one oRxReady.
- reset=1 at cycle 30 mid-byte → cycle 31: CS=1, SCLK=0, oBusy=0, oRx=0x00; no oRxReady.
- HOLDWAIT with iStart=1 and iHold=0 simultaneously → byte transmitted; CS stays low until that byte's TAIL ends.

Source files
------------

// File: rtl/spi_master_byte_if.sv
// spi_master_byte_if: host byte handshake and SPI pins of spi_master_byte.
interface spi_master_byte_if;
    logic       iStart;
    logic [7:0] iTx;
    logic       iHold;
    logic       oBusy;
    logic       oRxReady;
    logic [7:0] oRx;
    logic       oSPIClk;
    logic       oSPIMOSI;
    logic       iSPIMISO;
    logic       oSPICS;
    modport master (
        input  iStart, iTx, iHold, iSPIMISO,
        output oBusy, oRxReady, oRx, oSPIClk, oSPIMOSI, oSPICS
    );
    modport slave (
        output iStart, iTx, iHold, iSPIMISO,
        input  oBusy, oRxReady, oRx, oSPIClk, oSPIMOSI, oSPICS
    );
endinterface

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0 MSB-first SPI master, one byte per handshake, optional CS hold.
// Define SPI_MASTER_PROBE_EN to build the registered debug probe; otherwise probe is tied low.
module spi_master_byte #(
    parameter int CLKDIV = 4,
    parameter int CS_GAP = 2
) (
    input  logic              sysclk,
    input  logic              reset,
    spi_master_byte_if.master bus,
    output logic [15:0]       probe
);
    localparam int MAXC = (CLKDIV > CS_GAP) ? CLKDIV : CS_GAP;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(CS_GAP - 1);
    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TAIL, HOLDWAIT, GAP} state_t;
    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bitCnt;
    logic [7:0]    shiftReg;
    logic [7:0]    rxReg;
    logic          holdLatch;
    logic          misoMeta;
    logic          misoSync;
    logic          halfDone;
    assign halfDone = cnt == HALF_LAST;
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            bitCnt <= '0;
            shiftReg <= '0;
            rxReg <= '0;
            holdLatch <= 1'b0;
            misoMeta <= 1'b0;
            misoSync <= 1'b0;
            bus.oBusy <= 1'b0;
            bus.oRxReady <= 1'b0;
            bus.oRx <= '0;
            bus.oSPIClk <= 1'b0;
            bus.oSPIMOSI <= 1'b0;
            bus.oSPICS <= 1'b1;
        end else begin
            misoMeta <= bus.iSPIMISO;
            misoSync <= misoMeta;
            bus.oRxReady <= 1'b0;
            cnt <= cnt + 1'b1;
            case (state)
                IDLE: if (bus.iStart) begin
                    state <= SETUP;
                    cnt <= '0;
                    bitCnt <= '0;
                    shiftReg <= bus.iTx;
                    holdLatch <= bus.iHold;
                    bus.oSPICS <= 1'b0;
                    bus.oSPIMOSI <= bus.iTx[7];
                    bus.oBusy <= 1'b1;
                end
                SETUP, LOW: if (halfDone) begin
                    state <= HIGH;
                    cnt <= '0;
                    bus.oSPIClk <= 1'b1;
                end
                HIGH: if (halfDone) begin
                    // last cycle before SCLK falls: the synchronized MISO is settled here
                    cnt <= '0;
                    bitCnt <= bitCnt + 1'b1;
                    rxReg <= {rxReg[6:0], misoSync};
                    bus.oSPIClk <= 1'b0;
                    if (bitCnt == 3'd7) begin
                        state <= TAIL;
                        bus.oRx <= {rxReg[6:0], misoSync};
                        bus.oRxReady <= 1'b1;
                    end else begin
                        state <= LOW;
                        shiftReg <= {shiftReg[6:0], 1'b0};
                        bus.oSPIMOSI <= shiftReg[6];
                    end
                end
                TAIL: if (halfDone) begin
                    cnt <= '0;
                    if (holdLatch) begin
                        state <= HOLDWAIT;
                        bus.oBusy <= 1'b0;
                    end else begin
                        state <= GAP;
                        bus.oSPICS <= 1'b1;
                        bus.oSPIMOSI <= 1'b0;
                    end
                end
                HOLDWAIT: if (bus.iStart) begin
                    // chained byte skips SETUP: LOW already gives MOSI a full half-period
                    state <= LOW;
                    cnt <= '0;
                    bitCnt <= '0;
                    shiftReg <= bus.iTx;
                    holdLatch <= bus.iHold;
                    bus.oSPIMOSI <= bus.iTx[7];
                    bus.oBusy <= 1'b1;
                end else if (!bus.iHold) begin
                    state <= GAP;
                    cnt <= '0;
                    bus.oSPICS <= 1'b1;
                    bus.oSPIMOSI <= 1'b0;
                    bus.oBusy <= 1'b1;
                end
                GAP: if (cnt == GAP_LAST) begin
                    state <= IDLE;
                    bus.oBusy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef SPI_MASTER_PROBE_EN
    always_ff @(posedge sysclk) begin
        if (reset) probe <= '0;
        else probe <= {state, bitCnt, bus.oSPICS, bus.oSPIClk, shiftReg};
    end
`else
    assign probe = 16'h0000;
`endif
endmodule
